// File: rtl/pipe_fetch_hazard_ctrl.sv
// Front end and hazard controller for the IF/DOF/EX/WB pipeline: PC and IF/DOF register,
// branch redirect, operand forwarding selects, load-use stall and drain-then-halt sequencing.
module pipe_fetch_hazard_ctrl #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 11,
   parameter int REG_AW     = 5,
   parameter int LOAD_STALL = 1,
   parameter int HALT_DRAIN = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] imem_rdata_i,
   input  logic              imem_ready_i,
   input  logic [REG_AW-1:0] dof_aa_i,
   input  logic [REG_AW-1:0] dof_ba_i,
   input  logic              dof_use_a_i,
   input  logic              dof_use_b_i,
   input  logic              ex_rw_i,
   input  logic              ex_is_load_i,
   input  logic [REG_AW-1:0] ex_da_i,
   input  logic              wb_rw_i,
   input  logic [REG_AW-1:0] wb_da_i,
   input  logic [1:0]        ex_bs_i,
   input  logic              ex_ps_i,
   input  logic              ex_z_i,
   input  logic [DATA_W-1:0] ex_bra_off_i,
   input  logic [DATA_W-1:0] ex_raa_i,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic              imem_oen_o,
   output logic [DATA_W-1:0] ir_o,
   output logic [ADDR_W-1:0] pc_dof_o,
   output logic [ADDR_W-1:0] pc_ex_o,
   output logic              ex_kill_o,
   output logic              stall_o,
   output logic [1:0]        fwd_a_sel_o,
   output logic [1:0]        fwd_b_sel_o,
   output logic              halt_o
);

   localparam int CNT_W = (HALT_DRAIN > 0) ? $clog2(HALT_DRAIN + 1) : 1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [DATA_W-1:0]  ir_q, ir_d;
   logic               dof_valid_q, dof_valid_d;
   logic [ADDR_W-1:0]  pc_dof_q, pc_dof_d;
   logic [ADDR_W-1:0]  pc_ex_q, pc_ex_d;
   logic               ex_valid_q, ex_valid_d;
   logic               oen_q;
   logic               halt_q;

   logic               ex_live_s;
   logic [1:0]         c_sel_s;
   logic               taken_s;
   logic [ADDR_W-1:0]  target_s;
   logic               ex_a_s, ex_b_s, wb_a_s, wb_b_s;
   logic               load_use_s;
   logic               halt_det_s;
   logic               stall_s;
   logic               kill_s;

   function automatic logic reg_match(input logic              rw,
                                      input logic [REG_AW-1:0] da,
                                      input logic [REG_AW-1:0] src,
                                      input logic              use_r);
      return rw & (da != {REG_AW{1'b0}}) & (da == src) & use_r;
   endfunction

   // Only the low ADDR_W bits of the branch operands address instruction memory.
   generate
      if (DATA_W > ADDR_W) begin : g_unused_hi
         logic unused_hi_s;
         assign unused_hi_s = ^{ex_bra_off_i[DATA_W-1:ADDR_W], ex_raa_i[DATA_W-1:ADDR_W]};
      end
   endgenerate

   // EX bubbles are remembered from our own kills; nothing in EX may redirect once halted.
   assign ex_live_s  = ex_valid_q & (state_q != ST_HALT);
   assign c_sel_s    = ex_live_s ? {ex_bs_i[1], ((ex_ps_i ^ ex_z_i) | ex_bs_i[1]) & ex_bs_i[0]} : 2'b00;
   assign taken_s    = (c_sel_s != 2'b00);
   assign target_s   = (c_sel_s == 2'b10) ? ex_raa_i[ADDR_W-1:0] : (pc_ex_q + ex_bra_off_i[ADDR_W-1:0]);

   assign ex_a_s     = reg_match(ex_rw_i, ex_da_i, dof_aa_i, dof_use_a_i);
   assign ex_b_s     = reg_match(ex_rw_i, ex_da_i, dof_ba_i, dof_use_b_i);
   assign wb_a_s     = reg_match(wb_rw_i, wb_da_i, dof_aa_i, dof_use_a_i);
   assign wb_b_s     = reg_match(wb_rw_i, wb_da_i, dof_ba_i, dof_use_b_i);
   assign load_use_s = (LOAD_STALL != 0) & ex_is_load_i & (ex_a_s | ex_b_s);
   assign halt_det_s = dof_valid_q & (&ir_q);

   // Next-state selection for the fetch front end and the run/drain/halt sequencer.
   always_comb begin
      pc_d        = pc_q;
      ir_d        = ir_q;
      dof_valid_d = dof_valid_q;
      pc_dof_d    = pc_dof_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      stall_s     = 1'b0;
      kill_s      = 1'b0;
      if (taken_s) begin
         pc_d        = target_s;
         ir_d        = {DATA_W{1'b0}};
         dof_valid_d = 1'b0;
         kill_s      = 1'b1;
         state_d     = ST_RUN;
         cnt_d       = CNT_W'(0);
      end else begin
         case (state_q)
            ST_RUN: begin
               if (load_use_s) begin
                  stall_s = 1'b1;
                  kill_s  = 1'b1;
               end else if (halt_det_s) begin
                  kill_s      = 1'b1;
                  ir_d        = {DATA_W{1'b0}};
                  dof_valid_d = 1'b0;
                  cnt_d       = CNT_W'(HALT_DRAIN);
                  if (HALT_DRAIN == 0) begin
                     state_d = ST_HALT;
                  end else begin
                     state_d = ST_DRAIN;
                  end
               end else if (!imem_ready_i) begin
                  ir_d        = {DATA_W{1'b0}};
                  dof_valid_d = 1'b0;
               end else begin
                  ir_d        = imem_rdata_i;
                  dof_valid_d = 1'b1;
                  pc_dof_d    = pc_q;
                  pc_d        = pc_q + ADDR_W'(1);
               end
            end
            ST_DRAIN: begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = ST_HALT;
                  cnt_d   = CNT_W'(0);
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            ST_HALT: begin
               kill_s = 1'b1;
            end
            default: begin
               state_d = ST_HALT;
               kill_s  = 1'b1;
            end
         endcase
      end
   end

   assign pc_ex_d    = stall_s ? pc_ex_q : pc_dof_q;
   assign ex_valid_d = ~kill_s;

   // Pipeline front-end registers; fetch enable and halt are registered views of the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         cnt_q       <= CNT_W'(0);
         pc_q        <= {ADDR_W{1'b0}};
         ir_q        <= {DATA_W{1'b0}};
         dof_valid_q <= 1'b0;
         pc_dof_q    <= {ADDR_W{1'b0}};
         pc_ex_q     <= {ADDR_W{1'b0}};
         ex_valid_q  <= 1'b0;
         oen_q       <= 1'b1;
         halt_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         dof_valid_q <= dof_valid_d;
         pc_dof_q    <= pc_dof_d;
         pc_ex_q     <= pc_ex_d;
         ex_valid_q  <= ex_valid_d;
         oen_q       <= (state_d != ST_RUN);
         halt_q      <= (state_d == ST_HALT);
      end
   end

   assign imem_addr_o = pc_q;
   assign imem_oen_o  = oen_q;
   assign ir_o        = ir_q;
   assign pc_dof_o    = pc_dof_q;
   assign pc_ex_o     = pc_ex_q;
   assign ex_kill_o   = kill_s;
   assign stall_o     = stall_s;
   assign fwd_a_sel_o = ex_a_s ? 2'b01 : (wb_a_s ? 2'b10 : 2'b00);
   assign fwd_b_sel_o = ex_b_s ? 2'b01 : (wb_b_s ? 2'b10 : 2'b00);
   assign halt_o      = halt_q;

endmodule

// File: tb/tb_pipe_fetch_hazard_ctrl.sv
// Bench for pipe_fetch_hazard_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural pipeline model.
module tb_pipe_fetch_hazard_ctrl;
   localparam int HD = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] imem_rdata, rnd_rdata;
   logic        use_mem;
   logic        imem_ready;
   logic [4:0]  dof_aa, dof_ba, ex_da, wb_da;
   logic        dof_use_a, dof_use_b, ex_rw, ex_is_load, wb_rw, ex_ps, ex_z;
   logic [1:0]  ex_bs;
   logic [31:0] ex_bra_off, ex_raa;

   logic [10:0] imem_addr, pc_dof, pc_ex;
   logic        imem_oen, ex_kill, stall, halt;
   logic [31:0] ir;
   logic [1:0]  fwd_a, fwd_b;

   logic [10:0] ns_addr, ns_pc_dof, ns_pc_ex;
   logic        ns_oen, ns_kill, ns_stall, ns_halt;
   logic [31:0] ns_ir;
   logic [1:0]  ns_fa, ns_fb;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   // Instruction memory image: a recognisable word per address, or a forced word from the stimulus.
   always_comb imem_rdata = use_mem ? (32'hA500_0000 | {21'd0, imem_addr}) : rnd_rdata;

   pipe_fetch_hazard_ctrl #(.DATA_W(32), .ADDR_W(11), .REG_AW(5), .LOAD_STALL(1), .HALT_DRAIN(HD)) u_dut (
      .clk(clk), .rst_n(rst_n), .imem_rdata_i(imem_rdata), .imem_ready_i(imem_ready),
      .dof_aa_i(dof_aa), .dof_ba_i(dof_ba), .dof_use_a_i(dof_use_a), .dof_use_b_i(dof_use_b),
      .ex_rw_i(ex_rw), .ex_is_load_i(ex_is_load), .ex_da_i(ex_da), .wb_rw_i(wb_rw), .wb_da_i(wb_da),
      .ex_bs_i(ex_bs), .ex_ps_i(ex_ps), .ex_z_i(ex_z), .ex_bra_off_i(ex_bra_off), .ex_raa_i(ex_raa),
      .imem_addr_o(imem_addr), .imem_oen_o(imem_oen), .ir_o(ir), .pc_dof_o(pc_dof), .pc_ex_o(pc_ex),
      .ex_kill_o(ex_kill), .stall_o(stall), .fwd_a_sel_o(fwd_a), .fwd_b_sel_o(fwd_b), .halt_o(halt));

   pipe_fetch_hazard_ctrl #(.DATA_W(32), .ADDR_W(11), .REG_AW(5), .LOAD_STALL(0), .HALT_DRAIN(HD)) u_dut_ns (
      .clk(clk), .rst_n(rst_n), .imem_rdata_i(imem_rdata), .imem_ready_i(imem_ready),
      .dof_aa_i(dof_aa), .dof_ba_i(dof_ba), .dof_use_a_i(dof_use_a), .dof_use_b_i(dof_use_b),
      .ex_rw_i(ex_rw), .ex_is_load_i(ex_is_load), .ex_da_i(ex_da), .wb_rw_i(wb_rw), .wb_da_i(wb_da),
      .ex_bs_i(ex_bs), .ex_ps_i(ex_ps), .ex_z_i(ex_z), .ex_bra_off_i(ex_bra_off), .ex_raa_i(ex_raa),
      .imem_addr_o(ns_addr), .imem_oen_o(ns_oen), .ir_o(ns_ir), .pc_dof_o(ns_pc_dof), .pc_ex_o(ns_pc_ex),
      .ex_kill_o(ns_kill), .stall_o(ns_stall), .fwd_a_sel_o(ns_fa), .fwd_b_sel_o(ns_fb), .halt_o(ns_halt));

   // ---------------- behavioural model ----------------
   logic [10:0] m_pc, m_pc_dof, m_pc_ex, n_pc, n_pc_dof, n_pc_ex, e_target;
   logic [31:0] m_ir, n_ir;
   logic        m_dv, m_bub, m_halted, m_oen, n_dv, n_bub, n_halted, n_oen;
   int          m_left, n_left;
   logic [1:0]  e_fa, e_fb;
   logic        e_taken, e_stall, e_hdet, e_kill, running;

   function automatic logic [1:0] fsel(input logic use_r, input logic [4:0] src,
                                       input logic erw, input logic [4:0] eda,
                                       input logic wrw, input logic [4:0] wda);
      if (!use_r || src == 5'd0) return 2'd0;
      if (erw && eda == src) return 2'd1;
      if (wrw && wda == src) return 2'd2;
      return 2'd0;
   endfunction

   always_comb begin
      e_fa     = fsel(dof_use_a, dof_aa, ex_rw, ex_da, wb_rw, wb_da);
      e_fb     = fsel(dof_use_b, dof_ba, ex_rw, ex_da, wb_rw, wb_da);
      e_taken  = 1'b0;
      e_target = m_pc_ex + ex_bra_off[10:0];
      if (!m_halted && !m_bub) begin
         case (ex_bs)
            2'd1: e_taken = (ex_ps != ex_z);
            2'd2: begin e_taken = 1'b1; e_target = ex_raa[10:0]; end
            2'd3: e_taken = 1'b1;
            default: e_taken = 1'b0;
         endcase
      end
      running  = !m_halted && (m_left == 0);
      e_stall  = !e_taken && running && ex_is_load && (e_fa == 2'd1 || e_fb == 2'd1);
      e_hdet   = !e_taken && running && !e_stall && m_dv && (m_ir == 32'hFFFF_FFFF);
      e_kill   = e_taken || e_stall || e_hdet || m_halted;
      n_pc = m_pc; n_ir = m_ir; n_dv = m_dv; n_pc_dof = m_pc_dof;
      n_left = m_left; n_halted = m_halted;
      n_pc_ex = e_stall ? m_pc_ex : m_pc_dof;
      if (e_taken) begin
         n_pc = e_target; n_ir = 32'd0; n_dv = 1'b0; n_left = 0;
      end else if (m_halted) begin
         n_halted = 1'b1;
      end else if (m_left > 0) begin
         n_left = m_left - 1;
         if (m_left == 1) n_halted = 1'b1;
      end else if (e_stall) begin
         n_dv = m_dv;
      end else if (e_hdet) begin
         n_ir = 32'd0; n_dv = 1'b0; n_left = HD;
      end else if (!imem_ready) begin
         n_ir = 32'd0; n_dv = 1'b0;
      end else begin
         n_ir = imem_rdata; n_dv = 1'b1; n_pc_dof = m_pc; n_pc = m_pc + 11'd1;
      end
      n_oen = n_halted || (n_left > 0);
      n_bub = e_kill;
   end

   // Model state advances on the same edges as the design.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc <= 11'd0; m_ir <= 32'd0; m_dv <= 1'b0; m_pc_dof <= 11'd0; m_pc_ex <= 11'd0;
         m_bub <= 1'b1; m_halted <= 1'b0; m_left <= 0; m_oen <= 1'b1;
      end else begin
         m_pc <= n_pc; m_ir <= n_ir; m_dv <= n_dv; m_pc_dof <= n_pc_dof; m_pc_ex <= n_pc_ex;
         m_bub <= n_bub; m_halted <= n_halted; m_left <= n_left; m_oen <= n_oen;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_addr", {21'd0, imem_addr}, {21'd0, m_pc});
         chk("m_oen", {31'd0, imem_oen}, {31'd0, m_oen});
         chk("m_ir", ir, m_ir);
         chk("m_pc_dof", {21'd0, pc_dof}, {21'd0, m_pc_dof});
         chk("m_pc_ex", {21'd0, pc_ex}, {21'd0, m_pc_ex});
         chk("m_kill", {31'd0, ex_kill}, {31'd0, e_kill});
         chk("m_stall", {31'd0, stall}, {31'd0, e_stall});
         chk("m_fwd_a", {30'd0, fwd_a}, {30'd0, e_fa});
         chk("m_fwd_b", {30'd0, fwd_b}, {30'd0, e_fb});
         chk("m_halt", {31'd0, halt}, {31'd0, m_halted});
         chk("ns_stall", {31'd0, ns_stall}, 32'd0);
         chk("ns_fwd_b", {30'd0, ns_fb}, {30'd0, e_fb});
      end
   end

   task automatic idle();
      imem_ready = 1'b1; use_mem = 1'b1; rnd_rdata = 32'd0;
      dof_aa = 5'd0; dof_ba = 5'd0; dof_use_a = 1'b0; dof_use_b = 1'b0;
      ex_rw = 1'b0; ex_is_load = 1'b0; ex_da = 5'd0; wb_rw = 1'b0; wb_da = 5'd0;
      ex_bs = 2'b00; ex_ps = 1'b0; ex_z = 1'b0; ex_bra_off = 32'd0; ex_raa = 32'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      idle();
      #2 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      chk("rst_addr", {21'd0, imem_addr}, 32'd0);
      chk("rst_oen", {31'd0, imem_oen}, 32'd1);
      chk("rst_ir", ir, 32'd0);
      chk("rst_halt", {31'd0, halt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      // sequential fetch
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("seq_addr", {21'd0, imem_addr}, 32'(k));
         chk("seq_ir", ir, 32'hA500_0000 | 32'(k - 1));
         chk("seq_oen", {31'd0, imem_oen}, 32'd0);
      end
      // forwarding priority
      ex_rw = 1'b1; ex_da = 5'd3; dof_aa = 5'd3; dof_use_a = 1'b1; #1;
      chk("fwd_ex", {30'd0, fwd_a}, 32'd1);
      ex_da = 5'd0; #1;
      chk("fwd_r0", {30'd0, fwd_a}, 32'd0);
      ex_da = 5'd3; wb_rw = 1'b1; wb_da = 5'd3; #1;
      chk("fwd_prio", {30'd0, fwd_a}, 32'd1);
      ex_rw = 1'b0; #1;
      chk("fwd_wb", {30'd0, fwd_a}, 32'd2);
      // load-use
      idle(); ex_rw = 1'b1; ex_is_load = 1'b1; ex_da = 5'd4; dof_ba = 5'd4; dof_use_b = 1'b1; #1;
      chk("lu_stall", {31'd0, stall}, 32'd1);
      chk("lu_kill", {31'd0, ex_kill}, 32'd1);
      chk("lu_ns_stall", {31'd0, ns_stall}, 32'd0);
      chk("lu_ns_fwd", {30'd0, ns_fb}, 32'd1);
      tick();
      idle(); wb_rw = 1'b1; wb_da = 5'd4; dof_ba = 5'd4; dof_use_b = 1'b1; #1;
      chk("lu_addr", {21'd0, imem_addr}, 32'd3);
      chk("lu_ir", ir, 32'hA500_0002);
      chk("lu_fwd_wb", {30'd0, fwd_b}, 32'd2);
      chk("lu_stall2", {31'd0, stall}, 32'd0);
      // relative branch from pc_ex = 10
      idle();
      for (int i = 0; i < 30 && imem_addr != 11'd12; i++) tick();
      chk("br_reach", {21'd0, imem_addr}, 32'd12);
      chk("br_pc_ex", {21'd0, pc_ex}, 32'd10);
      ex_bs = 2'b01; ex_ps = 1'b0; ex_z = 1'b1; ex_bra_off = 32'd5; #1;
      chk("br_kill", {31'd0, ex_kill}, 32'd1);
      tick();
      chk("br_addr", {21'd0, imem_addr}, 32'd15);
      chk("br_ir", ir, 32'd0);
      ex_bs = 2'b10; ex_raa = 32'd100; #1;
      chk("br_bubble", {31'd0, ex_kill}, 32'd0);
      tick();
      chk("br_addr2", {21'd0, imem_addr}, 32'd16);
      ex_raa = 32'h0000_07FF; #1;
      chk("jr_kill", {31'd0, ex_kill}, 32'd1);
      tick();
      chk("jr_addr", {21'd0, imem_addr}, 32'd2047);
      idle(); tick();
      chk("wrap_addr", {21'd0, imem_addr}, 32'd0);
      chk("wrap_pc_dof", {21'd0, pc_dof}, 32'd2047);
      // reset mid-drain
      pulse_reset();
      tick();
      use_mem = 1'b0; rnd_rdata = 32'hFFFF_FFFF;
      tick(); use_mem = 1'b1;
      tick();
      chk("dr_oen", {31'd0, imem_oen}, 32'd1);
      rst_n = 1'b0; #1;
      chk("ar_addr", {21'd0, imem_addr}, 32'd0);
      chk("ar_oen", {31'd0, imem_oen}, 32'd1);
      chk("ar_ir", ir, 32'd0);
      chk("ar_pc_dof", {21'd0, pc_dof}, 32'd0);
      chk("ar_halt", {31'd0, halt}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      // taken branch during drain cancels the halt
      tick();
      use_mem = 1'b0; rnd_rdata = 32'hFFFF_FFFF;
      tick(); use_mem = 1'b1;
      tick();
      ex_bs = 2'b10; ex_raa = 32'h40; #1;
      chk("dbr_bubble", {31'd0, ex_kill}, 32'd0);
      tick();
      chk("dbr_kill", {31'd0, ex_kill}, 32'd1);
      tick();
      idle();
      chk("dbr_addr", {21'd0, imem_addr}, 32'h40);
      chk("dbr_oen", {31'd0, imem_oen}, 32'd0);
      tick(); tick(); tick();
      chk("dbr_halt", {31'd0, halt}, 32'd0);
      // fetch not ready for three cycles
      imem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("nr_addr", {21'd0, imem_addr}, 32'h43);
         chk("nr_ir", ir, 32'd0);
      end
      imem_ready = 1'b1;
      tick();
      chk("nr_resume", {21'd0, imem_addr}, 32'h44);
      chk("nr_ir2", ir, 32'hA500_0043);
      // halt after HD+1 edges, sticky
      use_mem = 1'b0; rnd_rdata = 32'hFFFF_FFFF;
      tick(); use_mem = 1'b1;
      chk("h_ir", ir, 32'hFFFF_FFFF);
      for (int k = 1; k <= HD + 3; k++) begin
         tick();
         chk("h_halt", {31'd0, halt}, (k >= HD + 1) ? 32'd1 : 32'd0);
         chk("h_oen", {31'd0, imem_oen}, 32'd1);
         chk("h_addr", {21'd0, imem_addr}, 32'h45);
      end
      chk("h_kill", {31'd0, ex_kill}, 32'd1);
      // randomized traffic with occasional asynchronous resets
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 49) == 0) rst_n = 1'b0;
         imem_ready = ($urandom_range(0, 6) != 0);
         use_mem    = 1'b0;
         rnd_rdata  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom();
         dof_aa     = 5'($urandom_range(0, 3));
         dof_ba     = 5'($urandom_range(0, 3));
         dof_use_a  = 1'($urandom_range(0, 1));
         dof_use_b  = 1'($urandom_range(0, 1));
         ex_rw      = 1'($urandom_range(0, 1));
         ex_is_load = 1'($urandom_range(0, 1));
         ex_da      = 5'($urandom_range(0, 3));
         wb_rw      = 1'($urandom_range(0, 1));
         wb_da      = 5'($urandom_range(0, 3));
         ex_bs      = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         ex_ps      = 1'($urandom_range(0, 1));
         ex_z       = 1'($urandom_range(0, 1));
         ex_bra_off = $urandom();
         ex_raa     = $urandom();
      end
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
